seq_frame_tx: RTL and testbench
===============================

Name: seq_frame_tx

Overview:
Serial frame transmitter that feeds the single-bit sequence-detector line.
- Accepts a parallel word through a Load/Ready handshake.
- Emits it on Out1 as a fixed 1,0 preamble, then DATA_W data bits MSB-first, then GAP_LEN idle-low cycles.
- Pulses Done when the frame completes.
- Sits upstream of the detector, driving its In1 input.

Parameters:
DATA_W, 8, payload width in bits (>=1)
GAP_LEN, 2, trailing low cycles after the last data bit (>=1)

Ports:
CLK  input  1  system clock; all state changes on the rising edge
RST  input  1  asynchronous, active-high reset
Load  input  1  request to start a frame; sampled only when Ready=1
DataIn  input  DATA_W  payload; captured on the edge where Load&&Ready
Ready  output  1  high only in IDLE; Load is accepted in this state
Out1  output  1  serial line to the detector
Busy  output  1  high in every state except IDLE
Done  output  1  one-cycle pulse on the first IDLE cycle after GAP

Behaviour:
- Reset (RST=1, asynchronous): state=IDLE, shift register=0, counter=0, Out1=0, Done=0, Busy=0, Ready=1. Load is ignored while RST=1.
- Reset mid-frame aborts immediately. No partial bits are emitted after RST deasserts.
- States and transitions:
  - IDLE: Out1=0. Load&&Ready -> PRE1; capture DataIn into shift register.
  - PRE1: Out1=1 for one cycle -> PRE0.
  - PRE0: Out1=0 for one cycle -> DATA; counter loads DATA_W-1.
  - DATA: Out1=shift register MSB; shift left by one each cycle. At counter==0 -> GAP, counter loads GAP_LEN-1; otherwise decrement.
  - GAP: Out1=0. At counter==0 -> IDLE and set Done; otherwise decrement.
  - Unused encodings -> IDLE, Out1=0.
- Out1, Ready and Busy are Moore outputs: decoded from the state and shift registers only. There is no combinational path from Load or DataIn to any output.
- Done is registered: high exactly one cycle, the first IDLE cycle after GAP. It is low in all other cycles.
- Latency: Load accepted at edge k -> Out1=1 in cycle k+1, first data bit in cycle k+3, Done in cycle k+3+DATA_W+GAP_LEN.
- Frame occupies 2+DATA_W+GAP_LEN cycles on Out1. At least one IDLE cycle always separates frames.
- Back-to-back: Load held high during the Done cycle is accepted on that edge. The next PRE1 follows immediately.
- Load while Busy=1 is ignored and not queued. DataIn changes after capture have no effect.
- Counter width: $clog2(max(DATA_W,GAP_LEN)). Minimum width is 1.

Decomposition:
- Package seq_tx_pkg holds:
  - state encoding localparams S_IDLE, S_PRE1, S_PRE0, S_DATA, S_GAP (3-bit);
  - preamble constant PREAMBLE=2'b10.
- One sub-module, seq_bit_counter: loadable down-counter with a zero flag. It is reused for both the DATA and GAP phases.
- The FSM, shift register and output decode stay in seq_frame_tx.

Test Plan:
1. RST=1 asserted asynchronously mid-cycle -> Out1=0, Ready=1, Busy=0, Done=0 without waiting for a CLK edge.
2. DATA_W=8, GAP_LEN=2; Load=1, DataIn=8'hA5 at edge 0 -> Out1 in cycles 1..12 = 1,0,1,0,1,0,0,1,0,1,0,0; Done=1 only in cycle 13; Ready=0 in cycles 1..12.
3. Load held high continuously with DataIn=8'hFF -> frames start at edges 0, 13, 26; each frame's Out1 = 1,0,then eight 1s,0,0.
4. Load=1 with DataIn=8'h00 in cycle 5 of a frame in progress -> ignored; current frame bits unchanged; no second frame starts.
5. RST pulsed during the DATA phase (cycle 6) -> Out1=0 immediately; no Done pulse; next Load with DataIn=8'h3C yields a complete, correct frame.
6. DATA_W=1, GAP_LEN=1, DataIn=1'b1 -> Out1 = 1,0,1,0; Done in cycle 5.

Source files
------------

// File: rtl/seq_tx_pkg.sv
// Shared definitions for the serial frame transmitter: the FSM state
// encoding, the preamble bit pattern and a counter-width helper.
package seq_tx_pkg;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE1 = 3'd1;
    localparam logic [2:0] S_PRE0 = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_GAP  = 3'd4;

    // Sent MSB first: bit 1 during PRE1, bit 0 during PRE0.
    localparam logic [1:0] PREAMBLE = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE = S_IDLE,
        ST_PRE1 = S_PRE1,
        ST_PRE0 = S_PRE0,
        ST_DATA = S_DATA,
        ST_GAP  = S_GAP
    } state_t;

    // The counter only ever holds DATA_W-1 or GAP_LEN-1, so the width is
    // $clog2 of the larger of the two, never narrower than one bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        int w;
        m = (a > b) ? a : b;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/seq_bit_counter.sv
// Loadable down-counter with a zero flag. The transmitter reloads it at the
// start of the DATA and GAP phases and steps it once per phase cycle.
module seq_bit_counter #(
    parameter int CNT_W = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count_reg;

    // Load has priority over decrement; idle otherwise.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (dec) begin
            count_reg <= count_reg - CNT_W'(1);
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: accepts a word on Load&&Ready and sends it on
// Out1 as preamble 1,0, DATA_W data bits MSB first, then GAP_LEN low cycles,
// followed by a one-cycle Done pulse in the first IDLE cycle.
module seq_frame_tx
    import seq_tx_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int GAP_LEN = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Load,
    input  logic [DATA_W-1:0] DataIn,
    output logic              Ready,
    output logic              Out1,
    output logic              Busy,
    output logic              Done
);

    localparam int CNT_W = cnt_width(DATA_W, GAP_LEN);

    state_t            state_reg;
    state_t            state_next;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] shift_next;
    logic [DATA_W-1:0] shift_left;
    logic              done_reg;
    logic              done_next;

    logic              cnt_load;
    logic [CNT_W-1:0]  cnt_load_value;
    logic              cnt_dec;
    logic              cnt_zero;

    // Shift register moved left by one with a zero fill at the LSB.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_shift
            if (gi == 0) begin : g_lsb
                assign shift_left[gi] = 1'b0;
            end else begin : g_upper
                assign shift_left[gi] = shift_reg[gi-1];
            end
        end
    endgenerate

    seq_bit_counter #(
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .CLK        (CLK),
        .RST        (RST),
        .load       (cnt_load),
        .load_value (cnt_load_value),
        .dec        (cnt_dec),
        .zero       (cnt_zero)
    );

    // State, payload shift register and registered Done pulse.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= ST_IDLE;
            shift_reg <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            shift_reg <= shift_next;
            done_reg  <= done_next;
        end
    end

    // Next-state logic, payload capture/shift and counter control.
    always_comb begin
        state_next     = state_reg;
        shift_next     = shift_reg;
        done_next      = 1'b0;
        cnt_load       = 1'b0;
        cnt_load_value = '0;
        cnt_dec        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (Load) begin
                    state_next = ST_PRE1;
                    shift_next = DataIn;
                end
            end
            ST_PRE1: begin
                state_next = ST_PRE0;
            end
            ST_PRE0: begin
                state_next     = ST_DATA;
                cnt_load       = 1'b1;
                cnt_load_value = CNT_W'(DATA_W - 1);
            end
            ST_DATA: begin
                shift_next = shift_left;
                if (cnt_zero) begin
                    state_next     = ST_GAP;
                    cnt_load       = 1'b1;
                    cnt_load_value = CNT_W'(GAP_LEN - 1);
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_zero) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Moore output decode from state and shift register only.
    always_comb begin
        Out1  = 1'b0;
        Ready = 1'b0;
        Busy  = 1'b1;
        case (state_reg)
            ST_IDLE: begin
                Ready = 1'b1;
                Busy  = 1'b0;
            end
            ST_PRE1: Out1 = PREAMBLE[1];
            ST_PRE0: Out1 = PREAMBLE[0];
            ST_DATA: Out1 = shift_reg[DATA_W-1];
            default: Out1 = 1'b0;
        endcase
    end

    assign Done = done_reg;

endmodule

// File: tb/tb_seq_frame_tx.sv
// Testbench for seq_frame_tx: table-driven frame checks, hand-written
// corner sequences and randomized traffic against a queue-based frame model.
module tb_seq_frame_tx;

    localparam int DW = 8;
    localparam int GL = 2;

    logic          CLK = 1'b0;
    logic          RST;
    logic          load;
    logic [DW-1:0] data_in;
    logic          ready, out1, busy, done;

    logic          load1;
    logic [0:0]    data1;
    logic          ready1, out11, busy1, done1;

    int n_pass  = 0;
    int n_total = 0;

    always #5 CLK = ~CLK;

    seq_frame_tx #(.DATA_W(DW), .GAP_LEN(GL)) u_dut (
        .CLK    (CLK),
        .RST    (RST),
        .Load   (load),
        .DataIn (data_in),
        .Ready  (ready),
        .Out1   (out1),
        .Busy   (busy),
        .Done   (done)
    );

    seq_frame_tx #(.DATA_W(1), .GAP_LEN(1)) u_dut1 (
        .CLK    (CLK),
        .RST    (RST),
        .Load   (load1),
        .DataIn (data1),
        .Ready  (ready1),
        .Out1   (out11),
        .Busy   (busy1),
        .Done   (done1)
    );

    // Reference model: the bits still to be shown on the line, oldest first.
    bit m_q[$];
    bit m_done;

    function automatic void model_reset();
        m_q.delete();
        m_done = 1'b0;
    endfunction

    // One rising edge of the frame protocol, using the inputs seen at that edge.
    function automatic void model_step();
        if (m_q.size() > 0) begin
            void'(m_q.pop_front());
            m_done = (m_q.size() == 0);
        end else begin
            m_done = 1'b0;
            if (load) begin
                m_q.push_back(1'b1);
                m_q.push_back(1'b0);
                for (int i = DW - 1; i >= 0; i--) m_q.push_back(data_in[i]);
                for (int i = 0; i < GL; i++) m_q.push_back(1'b0);
            end
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic check_model();
        chk("out1",  {31'd0, out1},  {31'd0, (m_q.size() > 0) ? m_q[0] : 1'b0});
        chk("ready", {31'd0, ready}, {31'd0, m_q.size() == 0});
        chk("busy",  {31'd0, busy},  {31'd0, m_q.size() != 0});
        chk("done",  {31'd0, done},  {31'd0, m_done});
    endtask

    // Advance one clock: edge, model update, then settle to the falling edge.
    task automatic step();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
    endtask

    typedef struct {
        logic          ld;
        logic [DW-1:0] d;
        logic          o;
        logic          r;
        logic          b;
        logic          dn;
    } vec_t;

    vec_t tab[14];
    vec_t tab1[6];
    int   done_cnt;

    initial begin
        // Frame 8'hA5: preamble 1,0 / 1,0,1,0,0,1,0,1 / gap 0,0 / Done.
        tab[0]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0};
        tab[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        tab[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
        tab[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        tab[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
        tab[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        tab[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        tab[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
        tab[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        tab[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
        tab[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        tab[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        tab[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
        tab[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        // DATA_W=1, GAP_LEN=1, bit 1: 1,0,1,0 then Done in cycle 5.
        tab1[0] = '{1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0};
        tab1[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        tab1[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
        tab1[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        tab1[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
        tab1[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};

        RST = 1'b1; load = 1'b0; data_in = '0; load1 = 1'b0; data1 = '0;
        model_reset();
        #12;
        chk("rst_out1",  {31'd0, out1},  32'd0);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_busy",  {31'd0, busy},  32'd0);
        chk("rst_done",  {31'd0, done},  32'd0);
        @(negedge CLK);
        RST = 1'b0;

        // Table: single frame on the 8-bit instance.
        for (int i = 0; i < 14; i++) begin
            load = tab[i].ld; data_in = tab[i].d;
            step();
            $display("vec %0d: out1=%0b ready=%0b busy=%0b done=%0b", i, out1, ready, busy, done);
            chk("tab_out1",  {31'd0, out1},  {31'd0, tab[i].o});
            chk("tab_ready", {31'd0, ready}, {31'd0, tab[i].r});
            chk("tab_busy",  {31'd0, busy},  {31'd0, tab[i].b});
            chk("tab_done",  {31'd0, done},  {31'd0, tab[i].dn});
        end
        load = 1'b0;

        // Table: minimal-width instance.
        for (int i = 0; i < 6; i++) begin
            load1 = tab1[i].ld; data1 = tab1[i].d[0:0];
            step();
            $display("vec1 %0d: out1=%0b ready=%0b busy=%0b done=%0b", i, out11, ready1, busy1, done1);
            chk("w1_out1",  {31'd0, out11},  {31'd0, tab1[i].o});
            chk("w1_ready", {31'd0, ready1}, {31'd0, tab1[i].r});
            chk("w1_busy",  {31'd0, busy1},  {31'd0, tab1[i].b});
            chk("w1_done",  {31'd0, done1},  {31'd0, tab1[i].dn});
        end
        load1 = 1'b0;

        // Load held high: frames back to back, Done at cycles 13, 26, 39.
        load = 1'b1; data_in = 8'hFF; done_cnt = 0;
        for (int i = 0; i < 39; i++) begin
            step();
            check_model();
            if (done) done_cnt++;
            $display("b2b %0d: out1=%0b done=%0b", i + 1, out1, done);
        end
        chk("b2b_done_count", done_cnt, 32'd3);
        load = 1'b0;
        step(); check_model();
        step(); check_model();

        // Load during a frame is ignored.
        load = 1'b1; data_in = 8'h5A;
        step(); check_model();
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin step(); check_model(); end
        load = 1'b1; data_in = 8'h00;
        step(); check_model();
        load = 1'b0; data_in = 8'hFF;
        for (int i = 0; i < 12; i++) begin
            step(); check_model();
            $display("ign: out1=%0b ready=%0b done=%0b", out1, ready, done);
        end
        chk("ign_idle", {31'd0, ready}, 32'd1);

        // Asynchronous reset in the DATA phase (cycle 6).
        load = 1'b1; data_in = 8'hC3;
        step(); check_model();
        load = 1'b0;
        for (int i = 0; i < 5; i++) begin step(); check_model(); end
        #2 RST = 1'b1;
        model_reset();
        #1;
        $display("async rst: out1=%0b ready=%0b busy=%0b done=%0b", out1, ready, busy, done);
        chk("arst_out1",  {31'd0, out1},  32'd0);
        chk("arst_ready", {31'd0, ready}, 32'd1);
        chk("arst_busy",  {31'd0, busy},  32'd0);
        chk("arst_done",  {31'd0, done},  32'd0);
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin step(); check_model(); end
        load = 1'b1; data_in = 8'h3C;
        step(); check_model();
        load = 1'b0;
        for (int i = 0; i < 13; i++) begin
            step(); check_model();
            $display("post-rst: out1=%0b done=%0b", out1, done);
        end

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 400; i++) begin
            load    = ($urandom_range(0, 3) == 0);
            data_in = DW'($urandom);
            step();
            check_model();
            $display("rnd %0d: load=%0b data=%02h out1=%0b ready=%0b done=%0b", i, load, data_in, out1, ready, done);
            if ($urandom_range(0, 49) == 0) begin
                #2 RST = 1'b1;
                model_reset();
                #1 check_model();
                @(negedge CLK);
                RST = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
